// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope generator and its serial VCA multiplier.
package adsr_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } adsr_state_e;

    localparam int unsigned ACC_W_DEFAULT = 16;

    // One operand-load cycle followed by eight shift-add cycles.
    localparam int unsigned MUL_CYCLES = 9;

endpackage

// File: rtl/adsr_vca_mul.sv
// Serial 8x8 shift-add multiplier: load on start, eight add cycles, one-cycle done pulse.
module adsr_vca_mul
    import adsr_pkg::*;
(
    input  logic       clk,
    input  logic       system_rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       done,
    output logic [7:0] product
);

    localparam int unsigned ADD_CYCLES = MUL_CYCLES - 1;

    logic [15:0] a_sh_q;
    logic [15:0] acc_q;
    logic [7:0]  b_sh_q;
    logic [3:0]  cnt_q;
    logic        done_q;

    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            a_sh_q <= '0;
            acc_q  <= '0;
            b_sh_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                a_sh_q <= {8'd0, a};
                b_sh_q <= b;
                acc_q  <= '0;
                cnt_q  <= 4'(ADD_CYCLES);
            end else if (cnt_q != 4'd0) begin
                if (b_sh_q[0]) begin
                    acc_q <= acc_q + a_sh_q;
                end
                a_sh_q <= a_sh_q << 1;
                b_sh_q <= b_sh_q >> 1;
                cnt_q  <= cnt_q - 4'd1;
                done_q <= (cnt_q == 4'd1);
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q[15:8];

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator with serial VCA. Define ADSR_EXP_RELEASE_EN for an
// exponential-like release tail (step grows with the current level).
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned ACC_W      = ACC_W_DEFAULT
) (
    input  logic       clk,
    input  logic       system_rst_n,
    input  logic       enable,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] release_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] audio_in,
    output logic [7:0] audio_out,
    output logic [7:0] env_level,
    output logic       env_active,
    output logic [2:0] env_state
);

    logic                  gate_s1_q;
    logic                  gate_s2_q;
    logic                  gate_prev_q;
    logic                  rise;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  tick;
    adsr_state_e           state_q;
    logic [ACC_W-1:0]      acc_q;
    logic                  env_active_q;
    logic [ACC_W:0]        att_sum;
    logic [ACC_W:0]        dec_diff;
    logic [ACC_W:0]        rel_step;
    logic [ACC_W-1:0]      sus_acc;
    logic [3:0]            vca_cnt_q;
    logic                  vca_start;
    logic                  vca_done;
    logic [7:0]            vca_product;
    logic [7:0]            audio_out_q;

    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            gate_s1_q   <= 1'b0;
            gate_s2_q   <= 1'b0;
            gate_prev_q <= 1'b0;
        end else begin
            gate_s1_q   <= gate;
            gate_s2_q   <= gate_s1_q;
            gate_prev_q <= gate_s2_q;
        end
    end

    assign rise = gate_s2_q & ~gate_prev_q;

    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            presc_q <= '0;
        end else if (enable) begin
            presc_q <= presc_q + PRESCALE_W'(1);
        end
    end

    assign tick = enable && (presc_q == {PRESCALE_W{1'b1}});

    assign att_sum  = {1'b0, acc_q} + (ACC_W+1)'(attack_rate);
    assign dec_diff = {1'b0, acc_q} - (ACC_W+1)'(decay_rate);
`ifdef ADSR_EXP_RELEASE_EN
    assign rel_step = (ACC_W+1)'(release_rate) + (ACC_W+1)'(acc_q >> 6);
`else
    assign rel_step = (ACC_W+1)'(release_rate);
`endif

    always_comb begin
        sus_acc = '0;
        sus_acc[ACC_W-1 -: 8] = sustain_level;
    end

    // Rise outranks everything and suppresses that cycle's step; a low gate
    // forces release from any sounding phase without waiting for a tick.
    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            env_active_q <= 1'b0;
        end else if (enable) begin
            if (rise) begin
                state_q      <= StAttack;
                env_active_q <= 1'b1;
            end else if (!gate_s2_q && (state_q inside {StAttack, StDecay, StSustain})) begin
                state_q      <= StRelease;
                env_active_q <= 1'b1;
            end else begin
                case (state_q)
                    StAttack: begin
                        if (tick) begin
                            if (attack_rate == 8'd0 || att_sum >= {1'b0, {ACC_W{1'b1}}}) begin
                                acc_q   <= '1;
                                state_q <= StDecay;
                            end else begin
                                acc_q <= att_sum[ACC_W-1:0];
                            end
                        end
                    end
                    StDecay: begin
                        if (tick) begin
                            if (decay_rate == 8'd0 || dec_diff[ACC_W] ||
                                dec_diff[ACC_W-1 -: 8] <= sustain_level) begin
                                acc_q   <= sus_acc;
                                state_q <= StSustain;
                            end else begin
                                acc_q <= dec_diff[ACC_W-1:0];
                            end
                        end
                    end
                    StSustain: begin
                        acc_q <= sus_acc;
                    end
                    StRelease: begin
                        if (tick) begin
                            if (release_rate == 8'd0 || rel_step >= {1'b0, acc_q}) begin
                                acc_q        <= '0;
                                state_q      <= StIdle;
                                env_active_q <= 1'b0;
                            end else begin
                                acc_q <= acc_q - rel_step[ACC_W-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            vca_cnt_q <= '0;
        end else if (vca_cnt_q == 4'(MUL_CYCLES - 1)) begin
            vca_cnt_q <= '0;
        end else begin
            vca_cnt_q <= vca_cnt_q + 4'd1;
        end
    end

    assign vca_start = (vca_cnt_q == 4'd0);

    adsr_vca_mul u_vca_mul (
        .clk          (clk),
        .system_rst_n (system_rst_n),
        .start        (vca_start),
        .a            (audio_in),
        .b            (env_level),
        .done         (vca_done),
        .product      (vca_product)
    );

    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            audio_out_q <= '0;
        end else if (!enable) begin
            audio_out_q <= '0;
        end else if (vca_done) begin
            audio_out_q <= vca_product;
        end
    end

    assign audio_out  = audio_out_q;
    assign env_level  = acc_q[ACC_W-1 -: 8];
    assign env_active = env_active_q;
    assign env_state  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed ADSR/VCA scenarios plus randomized gate traffic.
module tb_adsr_envelope;

    localparam int PW = 3;
    localparam int P  = 1 << PW;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic       clk = 1'b0;
    logic       system_rst_n;
    logic       enable;
    logic       gate;
    logic [7:0] attack_rate, decay_rate, release_rate, sustain_level, audio_in;
    logic [7:0] audio_out, env_level;
    logic       env_active;
    logic [2:0] env_state;

    adsr_envelope #(
        .PRESCALE_W (PW),
        .ACC_W      (16)
    ) dut (
        .clk           (clk),
        .system_rst_n  (system_rst_n),
        .enable        (enable),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_level (sustain_level),
        .audio_in      (audio_in),
        .audio_out     (audio_out),
        .env_level     (env_level),
        .env_active    (env_active),
        .env_state     (env_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: envelope as an integer level, phases from the rules.
    int m_acc, m_state, m_en, m_edge, m_aout, m_pending;
    bit m_tick;
    bit m_hist[$];

    typedef struct {
        logic [7:0] ain;
        logic [7:0] sus;
        logic [7:0] exp_out;
    } vca_vec_t;
    vca_vec_t vecs[7];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_state = S_IDLE; m_en = 0; m_edge = 0;
        m_aout = 0; m_pending = 0; m_tick = 0;
        m_hist = '{0, 0, 0};
    endtask

    task automatic step();
        int lvl, sync_g, prev_g, rise, sus, n, stp, act, exp;
        @(posedge clk);
        lvl = m_acc >> 8;
        sus = int'(sustain_level);
        if (!enable) m_aout = 0;
        else if (m_edge >= 9 && m_edge % 9 == 0) m_aout = m_pending;
        if (m_edge % 9 == 0) m_pending = (int'(audio_in) * lvl) >> 8;
        m_edge++;
        // gate samples taken two and three edges ago
        sync_g = int'(m_hist[1]);
        prev_g = int'(m_hist[2]);
        rise   = (sync_g == 1 && prev_g == 0) ? 1 : 0;
        m_hist.push_front(gate);
        void'(m_hist.pop_back());
        m_tick = 0;
        if (enable) begin
            m_tick = ((m_en % P) == P - 1);
            m_en++;
            if (rise == 1) m_state = S_ATT;
            else if (sync_g == 0 && (m_state == S_ATT || m_state == S_DEC || m_state == S_SUS))
                m_state = S_REL;
            else if (m_state == S_SUS) m_acc = sus << 8;
            else if (m_tick && m_state == S_ATT) begin
                if (attack_rate == 0 || m_acc + int'(attack_rate) >= 65535) begin
                    m_acc = 65535; m_state = S_DEC;
                end else m_acc = m_acc + int'(attack_rate);
            end else if (m_tick && m_state == S_DEC) begin
                n = m_acc - int'(decay_rate);
                if (decay_rate == 0 || n < 0 || (n >> 8) <= sus) begin
                    m_acc = sus << 8; m_state = S_SUS;
                end else m_acc = n;
            end else if (m_tick && m_state == S_REL) begin
                stp = int'(release_rate);
`ifdef ADSR_EXP_RELEASE_EN
                stp = stp + (m_acc >> 6);
`endif
                if (release_rate == 0 || stp >= m_acc) begin
                    m_acc = 0; m_state = S_IDLE;
                end else m_acc = m_acc - stp;
            end
        end
        #1;
        act = (int'(env_state) << 17) | (int'(env_level) << 9) | (int'(env_active) << 8)
            | int'(audio_out);
        exp = (m_state << 17) | ((m_acc >> 8) << 9) | ((m_state != S_IDLE ? 1 : 0) << 8)
            | m_aout;
        check("cycle{state,level,active,audio}", act, exp);
    endtask

    task automatic wait_state(int target, int budget, string name);
        int n = 0;
        while (int'(env_state) != target && n < budget) begin
            step();
            n++;
        end
        check(name, int'(env_state), target);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hold;
        logic [7:0] lvl_pre;
        logic [2:0] st_pre;

        vecs[0] = '{8'hFF, 8'h80, 8'h7F};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFE};
        vecs[2] = '{8'h80, 8'h80, 8'h40};
        vecs[3] = '{8'h00, 8'hAA, 8'h00};
        vecs[4] = '{8'h01, 8'hFF, 8'h00};
        vecs[5] = '{8'hC3, 8'h5A, 8'h44};
        vecs[6] = '{8'h7F, 8'hFE, 8'h7E};

        system_rst_n = 1'b0; enable = 1'b1; gate = 1'b0;
        attack_rate = 8'h00; decay_rate = 8'h00; release_rate = 8'h00;
        sustain_level = 8'h00; audio_in = 8'h00;
        model_reset();
        #12;
        check("rst_audio_out", int'(audio_out), 0);
        check("rst_env_level", int'(env_level), 0);
        check("rst_env_active", int'(env_active), 0);
        check("rst_env_state", int'(env_state), S_IDLE);
        @(negedge clk);
        system_rst_n = 1'b1;

        // Attack 0x80 saturates after 512 ticks, then DECAY.
        attack_rate = 8'h80; decay_rate = 8'h40; sustain_level = 8'h80;
        gate = 1'b1;
        wait_state(S_ATT, 8, "enter_attack");
        n = 0;
        while (int'(env_state) == S_ATT && n < 5000) begin step(); n++; end
        check("attack_edges_in_range", (n >= 511 * P + 1 && n <= 512 * P) ? 1 : 0, 1);
        check("attack_to_decay", int'(env_state), S_DEC);
        check("attack_saturated_level", int'(env_level), 8'hFF);

        // Decay 0x40 to sustain 0x80 takes exactly 508 ticks.
        n = 0;
        while (int'(env_state) == S_DEC && n < 5000) begin step(); n++; end
        check("decay_edges", n, 508 * P);
        check("decay_to_sustain", int'(env_state), S_SUS);
        check("sustain_level", int'(env_level), 8'h80);

        // Release rate 0 finishes at the next tick.
        gate = 1'b0;
        wait_state(S_REL, 4, "enter_release");
        wait_state(S_IDLE, P + 1, "release_instant_idle");
        check("idle_level", int'(env_level), 0);
        check("idle_active", int'(env_active), 0);

        // Retrigger during release keeps the current level.
        attack_rate = 8'h00; decay_rate = 8'h00; sustain_level = 8'h41;
        gate = 1'b1;
        wait_state(S_SUS, 4 * P, "reach_sustain_41");
        release_rate = 8'h80; attack_rate = 8'h10;
        gate = 1'b0;
        wait_state(S_REL, 4, "release_for_retrig");
        n = 0;
        while (env_level != 8'h40 && n < 4 * P) begin step(); n++; end
        check("release_reach_40", int'(env_level), 8'h40);
        gate = 1'b1;
        wait_state(S_ATT, 4, "retrig_attack");
        check("retrig_level_kept", int'(env_level), 8'h40);

        // Rise landing on a tick edge: no add that cycle.
        attack_rate = 8'hFF;
        gate = 1'b0;
        wait_state(S_REL, 4, "release_for_rise_tick");
        n = 0;
        while (!(((m_acc & 'hFF) == 'h80) && ((m_en + 3) % P == 0)) && n < 4 * P) begin
            step(); n++;
        end
        check("rise_tick_alignment_found", (n < 4 * P) ? 1 : 0, 1);
        lvl_pre = env_level;
        gate = 1'b1;
        repeat (3) step();
        check("rise_tick_state", int'(env_state), S_ATT);
        check("rise_tick_no_add", int'(env_level), int'(lvl_pre));
        repeat (P) step();
        check("rise_tick_next_add", int'(env_level), int'(lvl_pre) + 1);

        // Disable freezes the envelope and mutes the output.
        enable = 1'b0;
        repeat (2) step();
        check("disable_audio_zero", int'(audio_out), 0);
        lvl_pre = env_level; st_pre = env_state;
        repeat (40) step();
        check("disable_level_frozen", int'(env_level), int'(lvl_pre));
        check("disable_state_frozen", int'(env_state), int'(st_pre));
        enable = 1'b1;

        // Release from full scale with rate 1: first step size depends on build.
        attack_rate = 8'h00; decay_rate = 8'h01; release_rate = 8'h01;
        wait_state(S_DEC, 2 * P, "full_scale_decay");
        gate = 1'b0;
        wait_state(S_REL, 4, "full_scale_release");
        n = 0;
        do begin step(); n++; end while (!m_tick && n < 2 * P);
`ifdef ADSR_EXP_RELEASE_EN
        check("release_first_step", int'(env_level), 8'hFB);
`else
        check("release_first_step", int'(env_level), 8'hFF);
`endif

        // VCA vectors from sustain levels.
        release_rate = 8'h00;
        wait_state(S_IDLE, 2 * P, "vca_idle");
        attack_rate = 8'h00; decay_rate = 8'h00;
        sustain_level = vecs[0].sus;
        gate = 1'b1;
        wait_state(S_SUS, 4 * P, "vca_sustain");
        for (int i = 0; i < 7; i++) begin
            sustain_level = vecs[i].sus;
            audio_in      = vecs[i].ain;
            repeat (20) step();
            check($sformatf("vca_level[%0d]", i), int'(env_level), int'(vecs[i].sus));
            check($sformatf("vca_audio[%0d]", i), int'(audio_out), int'(vecs[i].exp_out));
        end

        // Async reset mid-attack, gate held high through release.
        gate = 1'b0;
        wait_state(S_IDLE, 2 * P + 4, "pre_reset_idle");
        attack_rate = 8'h20;
        gate = 1'b1;
        wait_state(S_ATT, 4, "pre_reset_attack");
        repeat (5 * P) step();
        #2;
        system_rst_n = 1'b0;
        #1;
        check("async_rst_audio_out", int'(audio_out), 0);
        check("async_rst_env_level", int'(env_level), 0);
        check("async_rst_env_active", int'(env_active), 0);
        check("async_rst_env_state", int'(env_state), S_IDLE);
        model_reset();
        repeat (2) @(negedge clk);
        system_rst_n = 1'b1;
        wait_state(S_ATT, 4, "post_reset_rise");

        // Randomized gate traffic against the model.
        hold = 0;
        for (int c = 0; c < 12000; c++) begin
            if (hold == 0) begin
                gate          = ~gate;
                hold          = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4)
                                                            : $urandom_range(10, 1500);
                attack_rate   = 8'($urandom_range(0, 255));
                decay_rate    = 8'($urandom_range(0, 255));
                release_rate  = 8'($urandom_range(0, 255));
                sustain_level = 8'($urandom_range(0, 255));
            end
            hold--;
            enable   = ($urandom_range(0, 49) != 0);
            audio_in = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
